// File: rtl/act_issuer.sv
// act_issuer: sequences the three configuration loads (bias, M_w, M_a) into
// the ACT unit, streams partial sums into it, packs the returned 8-bit
// results little-endian into 32-bit words and buffers them in a small FIFO.
//
// Optional feature: define ACT_ISSUER_SKIP_EN to skip any load whose value
// matches the last value issued since reset.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cfg_valid/cfg_ready      configuration handshake (ready only in IDLE)
//   cfg_bias, cfg_mw, cfg_ma bias b_f, M_w and M_a ({exp[31:16], mant[15:0]})
//   ps_valid/ps_ready        partial-sum handshake; ps_data, ps_last
//   op_type, data_in         registered ACT command and operand
//   data_act                 ACT result, ACT_LAT cycles after its command
//   out_valid/out_ready      packed-word handshake; out_data, out_last
//   busy                     state not IDLE or FIFO not empty
//
// state | meaning
// IDLE  | waiting for a configuration handshake
// LD_B  | issuing load of bias b_f (op_type 1)
// LD_MW | issuing load of M_w (op_type 2)
// LD_MA | issuing load of M_a (op_type 3)
// RUN   | accepting partial sums
// DRAIN | last sum accepted; waiting for results, flushing partial word
module act_issuer #(
   parameter int ACT_LAT    = 1,
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [15:0] cfg_bias,
   input  logic [31:0] cfg_mw,
   input  logic [31:0] cfg_ma,
   input  logic        ps_valid,
   output logic        ps_ready,
   input  logic [31:0] ps_data,
   input  logic        ps_last,
   output logic [1:0]  op_type,
   output logic [31:0] data_in,
   input  logic [7:0]  data_act,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy
);

   localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;

   typedef enum logic [2:0] {IDLE, LD_B, LD_MW, LD_MA, RUN, DRAIN} state_t;

   state_t state_q, state_d;

   logic [15:0] bias_q;
   logic [31:0] mw_q, ma_q;
   logic        need_b, need_mw, need_ma;
   logic        need_mw_q, need_ma_q;
   logic        cfg_fire, ps_fire;
   logic        issue_q;
   logic [ACT_LAT-1:0] tag_q;
   logic        cap;
   logic [3:0]  inflight;
   logic [5:0]  credit;
   logic [23:0] word_q;
   logic [1:0]  byte_cnt_q;
   logic        push, push_last, pop;
   logic [31:0] push_data;
   logic [32:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [2:0]  fifo_cnt_q;

`ifdef ACT_ISSUER_SKIP_EN
   logic cache_ok_q;
   assign need_b  = !cache_ok_q || (cfg_bias != bias_q);
   assign need_mw = !cache_ok_q || (cfg_mw != mw_q);
   assign need_ma = !cache_ok_q || (cfg_ma != ma_q);

   // The cfg registers double as the "last issued" cache: after a handshake
   // every differing value is loaded, so they always match what ACT holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cache_ok_q <= 1'b0;
      else if (cfg_fire) cache_ok_q <= 1'b1;
   end
`else
   assign need_b  = 1'b1;
   assign need_mw = 1'b1;
   assign need_ma = 1'b1;
`endif

   assign cfg_ready = (state_q == IDLE);
   assign cfg_fire  = cfg_valid && cfg_ready;
   assign ps_fire   = ps_valid && ps_ready;
   assign cap       = tag_q[ACT_LAT-1];

   always_comb begin
      inflight = {3'b000, issue_q};
      for (int i = 0; i < ACT_LAT; i++) inflight = inflight + {3'b000, tag_q[i]};
   end

   // Bytes committed (in flight, packed, or in the FIFO) may never exceed
   // the FIFO capacity, so a push always finds room.
   assign credit   = 6'(inflight) + 6'(byte_cnt_q) + {1'b0, fifo_cnt_q, 2'b00};
   assign ps_ready = (state_q == RUN) && (credit < 6'(4 * FIFO_DEPTH));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (cfg_valid)
                   state_d = need_b ? LD_B : need_mw ? LD_MW : need_ma ? LD_MA : RUN;
         LD_B:  state_d = need_mw_q ? LD_MW : need_ma_q ? LD_MA : RUN;
         LD_MW: state_d = need_ma_q ? LD_MA : RUN;
         LD_MA: state_d = RUN;
         RUN:   if (ps_fire && ps_last) state_d = DRAIN;
         DRAIN: if (inflight == 4'd0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Loads leaving IDLE take the operand straight from the cfg inputs, since
   // the cfg registers only capture it on that same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_type <= 2'd0;
         data_in <= 32'd0;
         issue_q <= 1'b0;
      end else begin
         issue_q <= ps_fire;
         case (state_d)
            LD_B: begin
               op_type <= 2'd1;
               data_in <= {16'h0000, (state_q == IDLE) ? cfg_bias : bias_q};
            end
            LD_MW: begin
               op_type <= 2'd2;
               data_in <= (state_q == IDLE) ? cfg_mw : mw_q;
            end
            LD_MA: begin
               op_type <= 2'd3;
               data_in <= (state_q == IDLE) ? cfg_ma : ma_q;
            end
            default: begin
               op_type <= 2'd0;
               data_in <= ps_fire ? ps_data : 32'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bias_q    <= 16'd0;
         mw_q      <= 32'd0;
         ma_q      <= 32'd0;
         need_mw_q <= 1'b1;
         need_ma_q <= 1'b1;
      end else if (cfg_fire) begin
         bias_q    <= cfg_bias;
         mw_q      <= cfg_mw;
         ma_q      <= cfg_ma;
         need_mw_q <= need_mw;
         need_ma_q <= need_ma;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tag_q <= '0;
      end else begin
         tag_q[0] <= issue_q;
         for (int i = 1; i < ACT_LAT; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   // Byte 0 clears the upper bytes so a flushed partial word is zero-padded.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q     <= 24'd0;
         byte_cnt_q <= 2'd0;
      end else if (cap) begin
         byte_cnt_q <= byte_cnt_q + 2'd1;
         case (byte_cnt_q)
            2'd0:    word_q <= {16'h0000, data_act};
            2'd1:    word_q[15:8]  <= data_act;
            2'd2:    word_q[23:16] <= data_act;
            default: word_q <= 24'd0;
         endcase
      end else if (push) begin
         word_q     <= 24'd0;
         byte_cnt_q <= 2'd0;
      end
   end

   // In DRAIN nothing new is issued, so a capture with one result left in
   // flight is the final byte of the stream.
   always_comb begin
      push      = 1'b0;
      push_data = 32'd0;
      push_last = 1'b0;
      if (cap && (byte_cnt_q == 2'd3)) begin
         push      = 1'b1;
         push_data = {data_act, word_q};
         push_last = (state_q == DRAIN) && (inflight == 4'd1);
      end else if ((state_q == DRAIN) && (inflight == 4'd0) && (byte_cnt_q != 2'd0)) begin
         push      = 1'b1;
         push_data = {8'h00, word_q};
         push_last = 1'b1;
      end
   end

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign out_valid = (fifo_cnt_q != 3'd0);
   assign pop       = out_valid && out_ready;
   assign out_data  = out_valid ? mem[rd_ptr_q][31:0] : 32'd0;
   assign out_last  = out_valid ? mem[rd_ptr_q][32] : 1'b0;
   assign busy      = (state_q != IDLE) || out_valid;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= {push_last, push_data};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= 3'd0;
      end else begin
         if (push) wr_ptr_q <= ptr_next(wr_ptr_q);
         if (pop)  rd_ptr_q <= ptr_next(rd_ptr_q);
         fifo_cnt_q <= fifo_cnt_q + {2'b00, push} - {2'b00, pop};
      end
   end

endmodule

// File: tb/tb_act_issuer.sv
module tb_act_issuer;
   localparam int ACT_LAT    = 1;
   localparam int FIFO_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid, cfg_ready;
   logic [15:0] cfg_bias;
   logic [31:0] cfg_mw, cfg_ma;
   logic        ps_valid, ps_ready, ps_last;
   logic [31:0] ps_data;
   logic [1:0]  op_type;
   logic [31:0] data_in;
   logic [7:0]  data_act;
   logic        out_valid, out_ready, out_last, busy;
   logic [31:0] out_data;

   int checks = 0;
   int errors = 0;

   act_issuer #(.ACT_LAT(ACT_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_bias(cfg_bias), .cfg_mw(cfg_mw), .cfg_ma(cfg_ma),
      .ps_valid(ps_valid), .ps_ready(ps_ready), .ps_data(ps_data), .ps_last(ps_last),
      .op_type(op_type), .data_in(data_in), .data_act(data_act),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy)
   );

   always #5 clk = ~clk;

   // ACT stand-in: result of the operand on data_in, ACT_LAT cycles later.
   function automatic logic [7:0] act_f(input logic [31:0] x);
      return x[7:0] ^ x[15:8] ^ 8'h5A;
   endfunction

   logic [7:0] act_pipe [ACT_LAT];
   always @(posedge clk) begin
      act_pipe[0] <= act_f(data_in);
      for (int i = 1; i < ACT_LAT; i++) act_pipe[i] <= act_pipe[i-1];
   end
   assign data_act = act_pipe[ACT_LAT-1];

   logic [32:0] got_q [$];
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) got_q.push_back({out_last, out_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_full(input logic [15:0] b, input logic [31:0] mw, input logic [31:0] ma);
      check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
      cfg_valid = 1'b1; cfg_bias = b; cfg_mw = mw; cfg_ma = ma;
      tick();
      cfg_valid = 1'b0;
      check("ld_b_op", 32'(op_type), 32'd1);
      check("ld_b_data", data_in, {16'h0000, b});
      check("ld_cfg_ready", 32'(cfg_ready), 32'd0);
      tick();
      check("ld_mw_op", 32'(op_type), 32'd2);
      check("ld_mw_data", data_in, mw);
      tick();
      check("ld_ma_op", 32'(op_type), 32'd3);
      check("ld_ma_data", data_in, ma);
      tick();
      check("run_op", 32'(op_type), 32'd0);
      check("run_ps_ready", 32'(ps_ready), 32'd1);
   endtask

   task automatic cfg_go(input logic [15:0] b, input logic [31:0] mw, input logic [31:0] ma);
      int n;
      cfg_valid = 1'b1; cfg_bias = b; cfg_mw = mw; cfg_ma = ma;
      tick();
      cfg_valid = 1'b0;
      n = 0;
      while (!ps_ready && n < 20) begin tick(); n++; end
      check("cfg_go_run", 32'(ps_ready), 32'd1);
   endtask

   task automatic send(input logic [31:0] v, input logic last);
      int n;
      ps_valid = 1'b1; ps_data = v; ps_last = last;
      n = 0;
      while (!ps_ready && n < 200) begin tick(); n++; end
      if (n >= 200) check("send_timeout", 32'(n), 32'd0);
      tick();
      ps_valid = 1'b0; ps_last = 1'b0; ps_data = 32'd0;
   endtask

   task automatic wait_words(input int n);
      int k;
      k = 0;
      while (got_q.size() < n && k < 300) begin tick(); k++; end
      check("word_count", 32'(got_q.size()), 32'(n));
   endtask

   task automatic expect_word(input string tag, input logic [31:0] d, input logic last);
      logic [32:0] w;
      w = (got_q.size() != 0) ? got_q.pop_front() : 33'h0;
      check({tag, "_data"}, w[31:0], d);
      check({tag, "_last"}, 32'(w[32]), 32'(last));
   endtask

   task automatic check_idle(input string tag);
      tick(); tick();
      check({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   logic [31:0] v31 [12];
   logic [31:0] w_exp;

   initial begin
      rst = 1'b1; cfg_valid = 1'b0; cfg_bias = '0; cfg_mw = '0; cfg_ma = '0;
      ps_valid = 1'b0; ps_data = '0; ps_last = 1'b0; out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rst_op", 32'(op_type), 32'd0);
      check("rst_data_in", data_in, 32'd0);
      check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
      check("rst_ps_ready", 32'(ps_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);

      // load sequence and one full word
      cfg_full(16'd50, 32'hFFFD0001, 32'hFFFF0004);
      send(32'd64, 1'b0);
      send(32'd513, 1'b0);
      send(-32'sd294, 1'b0);
      send(32'd1183, 1'b1);
      wait_words(1);
      expect_word("full_word", 32'hC17E591A, 1'b1);
      check_idle("full_idle");

      // three sums: zero-padded top byte
      cfg_go(16'd50, 32'hFFFD0001, 32'hFFFF0004);
      send(32'd10, 1'b0);
      send(32'd20, 1'b0);
      send(32'd30, 1'b1);
      wait_words(1);
      expect_word("pad_word", 32'h00444E50, 1'b1);
      check_idle("pad_idle");

      // backpressure: credit stops acceptance at 8 sums
      for (int i = 0; i < 12; i++) v31[i] = 32'(i * 7 + 1);
      cfg_go(16'd50, 32'hFFFD0001, 32'hFFFF0004);
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(v31[i], 1'b0);
      ps_valid = 1'b1; ps_data = v31[8];
      repeat (10) tick();
      check("bp_ps_ready", 32'(ps_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_no_pop", 32'(got_q.size()), 32'd0);
      out_ready = 1'b1;
      for (int i = 8; i < 12; i++) send(v31[i], i == 11);
      wait_words(3);
      for (int k = 0; k < 3; k++) begin
         w_exp = {act_f(v31[4*k+3]), act_f(v31[4*k+2]), act_f(v31[4*k+1]), act_f(v31[4*k])};
         expect_word("bp_word", w_exp, k == 2);
      end
      check_idle("bp_idle");

      // reset mid-RUN with sums in flight
      cfg_go(16'd50, 32'hFFFD0001, 32'hFFFF0004);
      send(32'd100, 1'b0);
      send(32'd200, 1'b0);
      send(32'd300, 1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_op", 32'(op_type), 32'd0);
      check("mid_rst_data_in", data_in, 32'd0);
      check("mid_rst_ps_ready", 32'(ps_ready), 32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_data", out_data, 32'd0);
      check("mid_rst_out_last", 32'(out_last), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      got_q.delete();
      cfg_full(16'd50, 32'hFFFD0001, 32'hFFFF0004);
      send(32'd5, 1'b1);
      wait_words(1);
      expect_word("post_rst_word", 32'h0000005F, 1'b1);
      check_idle("post_rst_idle");

`ifdef ACT_ISSUER_SKIP_EN
      // identical configuration: straight to RUN
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      check("skip_all_op", 32'(op_type), 32'd0);
      check("skip_all_run", 32'(ps_ready), 32'd1);
      send(32'd9, 1'b1);
      wait_words(1);
      expect_word("skip_all_word", 32'h00000053, 1'b1);
      check_idle("skip_all_idle");
      // only M_a changed
      cfg_valid = 1'b1; cfg_ma = 32'h00050006;
      tick();
      cfg_valid = 1'b0;
      check("skip_ma_op", 32'(op_type), 32'd3);
      check("skip_ma_data", data_in, 32'h00050006);
      tick();
      check("skip_ma_run", 32'(ps_ready), 32'd1);
      send(32'd9, 1'b1);
      wait_words(1);
      expect_word("skip_ma_word", 32'h00000053, 1'b1);
      check_idle("skip_ma_idle");
`else
      // identical configuration still issues every load
      cfg_full(16'd50, 32'hFFFD0001, 32'hFFFF0004);
      send(32'd9, 1'b1);
      wait_words(1);
      expect_word("repeat_word", 32'h00000053, 1'b1);
      check_idle("repeat_idle");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
